serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Receive end of the team's source-synchronous serial link: captures FRAME_BITS-bit frames sent as link clock clkIn plus data dataIn.
- Runs entirely on the system clk and oversamples the link through synchronizers, so there is no logic clocked by clkIn.
- Presents each completed frame on receiveBuffer with a newData/dataAck handshake.
- Detects stalled or overrun frames and reports them on frameError.

Parameters:
- FRAME_BITS, 256, payload bits per frame.
- SYNC_STAGES, 2, synchronizer flops on clkIn and dataIn (minimum 2).
- IDLE_TIMEOUT, 64, clk cycles without a clkIn falling edge that aborts a partial frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clkIn  input  1  link clock from the transmitter. Asynchronous to clk. Period is at least 8 clk cycles.
- dataIn  input  1  link data. Transmitter launches it on clkIn rising edge.
- readyForReceive  output  1  high while the block can accept a new frame.
- receiveBuffer  output  FRAME_BITS  last completed frame.
- newData  output  1  frame valid. Level signal, held until acknowledged.
- dataAck  input  1  consumer acknowledge of the current frame.
- frameError  output  1  one-cycle pulse on abort, overrun or parity failure.

Behaviour:
- Reset: all outputs go to 0 immediately (asynchronous) and stay 0 while rst is high: readyForReceive=0, newData=0, frameError=0, receiveBuffer=0. State=IDLE, counters=0. First cycle after rst deasserts, readyForReceive=1.
- Synchronization: clkIn and dataIn each pass through SYNC_STAGES flops. A sample event occurs when the synchronized clkIn is 1 in the previous cycle and 0 in the current cycle (falling edge). At that event, synchronized dataIn is the bit taken.
- Bit order: the first bit received goes to bit 0. Bit k goes to index k.
- Bit counter width is $clog2(FRAME_BITS+1). Timeout counter width is $clog2(IDLE_TIMEOUT+1).
- States:
  - IDLE: readyForReceive=1. A sample event writes shift[0], sets bitCount=1, clears the timeout counter, and moves to SHIFT.
  - SHIFT: readyForReceive=1. Each sample event writes shift[bitCount], increments bitCount and clears the timeout counter. With no event, the timeout counter increments.
    - Frame complete: on the cycle after bitCount reaches FRAME_BITS, receiveBuffer<=shift and newData<=1, then go to HOLD. Latency from the last sample event to newData=1 is exactly 1 clk.
    - Timeout: if the timeout counter reaches IDLE_TIMEOUT, pulse frameError, discard the frame (receiveBuffer unchanged), go to IDLE.
  - HOLD: readyForReceive=0 and newData=1.
    - dataAck=1 clears newData in the next cycle and returns to IDLE.
    - A sample event in HOLD is dropped and pulses frameError (overrun). receiveBuffer stays unchanged.
- Simultaneous dataAck and a sample event in HOLD: the overrun takes priority. The bit is dropped with an error pulse, and the ack is still honoured.
- dataAck outside HOLD is ignored.
- rst mid-frame clears the partial frame and any pending newData. No frameError pulse is produced on reset.
- frameError is registered: high exactly 1 clk per error event.

Optional Feature:
- SERIAL_RX_PARITY_EN defined: each frame carries one extra even-parity bit after FRAME_BITS payload bits, so the bit counter extends to FRAME_BITS+1. Once that bit is received:
  - Parity of payload XOR the parity bit is 0: behaves as "frame complete" above.
  - Parity check fails: pulse frameError, newData stays 0, receiveBuffer unchanged, go to IDLE.
- Not defined: no parity bit. Frame length is exactly FRAME_BITS.

Decomposition:
- Package serial_link_pkg holds:
  - FRAME_BITS default.
  - state enum {IDLE, SHIFT, HOLD}.
  - bit-counter width function.
  - parity-bit count constant (0/1 under SERIAL_RX_PARITY_EN).
- Sub-module link_sync_edge: SYNC_STAGES synchronizer for clkIn/dataIn plus falling-edge detect. Outputs sampleEvent and sampleData.

Test Plan:
- Reset then frame 256'h1 | (1<<255), clkIn period 8 clk, dataAck held 0 -> newData=1 exactly 1 clk after the 256th sample event. receiveBuffer=256'h8000…0001. readyForReceive=0. frameError never pulses.
- Pulse dataAck for 1 clk, then send a second frame 256'h0303…AAAA -> newData falls next cycle and readyForReceive=1. After the second frame, receiveBuffer=256'h0303…AAAA.
- Stop clkIn after 100 bits for 70 clk -> one frameError pulse after IDLE_TIMEOUT=64 idle cycles, state IDLE, newData=0. The next full frame is received correctly.
- Hold newData (no ack) and send 3 extra clkIn edges -> 3 separate frameError pulses. receiveBuffer is unchanged.
- Assert rst for 2 clk at bit 120 -> all outputs 0 during reset. The next frame is received intact with no spurious newData or frameError.
- With SERIAL_RX_PARITY_EN: a frame of 256'h3 with parity bit 1 -> frameError pulse and no newData. The same frame with parity bit 0 -> newData=1.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared constants for the serial link receiver: default frame length,
// FSM state codes, counter width helper and the parity-bit count.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds one even-parity bit per frame).
package serial_link_pkg;

   localparam int FRAME_BITS_DEF = 256;

   // FSM state codes
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

`ifdef SERIAL_RX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Width of a counter that must be able to hold the value max_count.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/link_sync_edge.sv
// Brings the link clock and data into the system clock domain and flags the
// link clock falling edge, which is the moment the data bit is taken.
// SYNC_STAGES must be at least 2.
module link_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clk_link,
   input  logic i_data_link,
   output logic o_sample_event,
   output logic o_sample_data
);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_prev;

   // Synchronizer chains plus one history flop for falling-edge detection.
   // Data travels through the same depth as the clock so both stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync  <= '0;
         r_data_sync <= '0;
         r_clk_prev  <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_clk_link};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data_link};
         r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign o_sample_event = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign o_sample_data  = r_data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_frame_rx.sv
// Receive end of the source-synchronous serial link. Oversamples clkIn/dataIn
// on the system clock, assembles FRAME_BITS-bit frames (first bit -> bit 0),
// hands them out with a newData/dataAck handshake and pulses frameError on
// timeout, overrun or (optionally) parity failure.
// Optional feature macro: SERIAL_RX_PARITY_EN.
module serial_frame_rx
   import serial_link_pkg::*;
#(
   parameter int FRAME_BITS   = FRAME_BITS_DEF,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clkIn,
   input  logic                  dataIn,
   output logic                  readyForReceive,
   output logic [FRAME_BITS-1:0] receiveBuffer,
   output logic                  newData,
   input  logic                  dataAck,
   output logic                  frameError
);

   localparam int TOTAL_BITS = FRAME_BITS + PARITY_BITS;
   localparam int CNT_W      = cnt_width(TOTAL_BITS);
   localparam int TMO_W      = cnt_width(IDLE_TIMEOUT);

   localparam logic [CNT_W-1:0] CNT_PAYLOAD = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TOTAL_BITS);
   localparam logic [TMO_W-1:0] TMO_LIMIT   = TMO_W'(IDLE_TIMEOUT);

   logic                  w_sample_event;
   logic                  w_sample_data;
   logic                  w_shift_en;
   logic                  w_frame_ok;

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [TMO_W-1:0]      r_tmo;
   logic [FRAME_BITS-1:0] r_shift;
   logic [FRAME_BITS-1:0] r_buf;
   logic                  r_new;
   logic                  r_ready;
   logic                  r_err;

   link_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk            (clk),
      .rst            (rst),
      .i_clk_link     (clkIn),
      .i_data_link    (dataIn),
      .o_sample_event (w_sample_event),
      .o_sample_data  (w_sample_data)
   );

   // Payload bits enter at the top and move down; after FRAME_BITS shifts the
   // first received bit sits at index 0. Bits arriving in HOLD are dropped.
   assign w_shift_en = w_sample_event &
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_SHIFT) && (r_cnt < CNT_PAYLOAD)));

   // Payload shift register; every bit is overwritten before it is published.
   always_ff @(posedge clk) begin
      if (w_shift_en)
         r_shift <= (r_shift >> 1) | (FRAME_BITS'(w_sample_data) << (FRAME_BITS - 1));
   end

`ifdef SERIAL_RX_PARITY_EN
   logic r_par;

   // Capture the trailing parity bit that follows the payload.
   always_ff @(posedge clk) begin
      if (w_sample_event && (r_state == ST_SHIFT) && (r_cnt == CNT_PAYLOAD))
         r_par <= w_sample_data;
   end

   assign w_frame_ok = ~(^r_shift ^ r_par);
`else
   assign w_frame_ok = 1'b1;
`endif

   // Frame FSM: collect bits, publish complete frames, flag timeout/overrun/parity errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_tmo   <= '0;
         r_buf   <= '0;
         r_new   <= 1'b0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err   <= 1'b0;
         r_ready <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_sample_event) begin
                  r_cnt   <= CNT_W'(1);
                  r_tmo   <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (r_cnt == CNT_LAST) begin
                  // Last bit landed on the previous edge; decide the frame now.
                  r_cnt <= '0;
                  r_tmo <= '0;
                  if (w_frame_ok) begin
                     r_buf   <= r_shift;
                     r_new   <= 1'b1;
                     r_ready <= 1'b0;
                     r_state <= ST_HOLD;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else if (w_sample_event) begin
                  r_cnt <= r_cnt + 1'b1;
                  r_tmo <= '0;
               end else if (r_tmo == TMO_LIMIT) begin
                  // Link went quiet mid-frame: discard the partial frame.
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
                  r_tmo   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            ST_HOLD: begin
               r_ready <= 1'b0;
               // Overrun is reported even when the ack arrives in the same cycle.
               if (w_sample_event)
                  r_err <= 1'b1;
               if (dataAck) begin
                  r_new   <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_tmo   <= '0;
               r_new   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign readyForReceive = r_ready;
   assign receiveBuffer   = r_buf;
   assign newData         = r_new;
   assign frameError      = r_err;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table of directed frames, timeout / overrun /
// mid-frame reset sequences, optional parity sequence and random frames
// checked against a frame-level reference model.
module tb_serial_frame_rx;

   localparam int FB  = 256;
   localparam int SS  = 2;
   localparam int TMO = 64;

   logic          clk;
   logic          rst;
   logic          clkIn;
   logic          dataIn;
   logic          dataAck;
   logic          readyForReceive;
   logic          newData;
   logic          frameError;
   logic [FB-1:0] receiveBuffer;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            err_seen = 0;
   int            nd_rise_cyc = -100;
   int            fall_cyc = 0;
   logic          nd_prev = 1'b0;
   logic [FB-1:0] last_buf;

   typedef struct {
      logic [FB-1:0] frame;
      int            extra;
      logic [FB-1:0] exp_buf;
      int            exp_err;
   } vec_t;

   vec_t vt[5];

   serial_frame_rx #(
      .FRAME_BITS   (FB),
      .SYNC_STAGES  (SS),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .clkIn           (clkIn),
      .dataIn          (dataIn),
      .readyForReceive (readyForReceive),
      .receiveBuffer   (receiveBuffer),
      .newData         (newData),
      .dataAck         (dataAck),
      .frameError      (frameError)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs on the inactive edge: error-cycle count and newData rise time.
   always @(negedge clk) begin
      if (frameError === 1'b1) err_seen++;
      if (newData === 1'b1 && nd_prev !== 1'b1) nd_rise_cyc = cyc;
      nd_prev = newData;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_w(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One link bit: data launched with the clkIn rise, taken at the clkIn fall.
   task automatic send_bit(input logic b, input int hi, input int lo);
      dataIn = b;
      clkIn  = 1'b1;
      tick(hi);
      clkIn    = 1'b0;
      fall_cyc = cyc;
      tick(lo);
   endtask

   task automatic send_bits(input logic [FB-1:0] f, input int n, input bit rnd);
      for (int k = 0; k < n; k++)
         send_bit(f[k], rnd ? int'($urandom_range(4, 6)) : 4, rnd ? int'($urandom_range(4, 6)) : 4);
   endtask

   task automatic send_frame(input logic [FB-1:0] f, input bit rnd);
      send_bits(f, FB, rnd);
`ifdef SERIAL_RX_PARITY_EN
      send_bit(^f, 4, 4);
`endif
   endtask

   // Bounded wait for newData, then check its rise came SS+2 cycles after the
   // last clkIn fall: synchronizer depth, event capture, then publication.
   task automatic wait_new(input string tag);
      int waited = 0;
      while (newData !== 1'b1 && waited < 20) begin
         tick(1);
         waited++;
      end
      @(negedge clk);
      #1;
      check_i({tag, " newData"}, int'(newData), 1);
      check_i({tag, " latency"}, nd_rise_cyc - fall_cyc, SS + 2);
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack(input string tag);
      dataAck = 1'b1;
      tick(1);
      dataAck = 1'b0;
      check_i({tag, " ack clears newData"}, int'(newData), 0);
      check_i({tag, " ready after ack"}, int'(readyForReceive), 1);
   endtask

   task automatic run_vec(input string tag, input logic [FB-1:0] f, input int extra,
                          input logic [FB-1:0] exp_buf, input int exp_err, input bit rnd);
      int e0;
      e0          = err_seen;
      nd_rise_cyc = -100;
      send_frame(f, rnd);
      wait_new(tag);
      check_w({tag, " buffer"}, receiveBuffer, exp_buf);
      check_i({tag, " ready in hold"}, int'(readyForReceive), 0);
      check_i({tag, " no error"}, err_seen - e0, 0);
      for (int k = 0; k < extra; k++)
         send_bit(1'($urandom_range(0, 1)), 4, 4);
      if (extra > 0) begin
         tick(4);
         check_i({tag, " overrun pulses"}, err_seen - e0, exp_err);
         check_w({tag, " buffer kept"}, receiveBuffer, exp_buf);
         check_i({tag, " newData held"}, int'(newData), 1);
      end
      if (rnd) tick(int'($urandom_range(1, 5)));
      do_ack(tag);
      last_buf = exp_buf;
   endtask

   task automatic check_all_zero(input string tag);
      check_i({tag, " ready"}, int'(readyForReceive), 0);
      check_i({tag, " newData"}, int'(newData), 0);
      check_i({tag, " frameError"}, int'(frameError), 0);
      check_w({tag, " buffer"}, receiveBuffer, '0);
   endtask

   initial begin
      logic [FB-1:0] f;
      logic [FB-1:0] f1;
      logic [FB-1:0] f2;
      int            e0;
      int            extra;

      rst     = 1'b0;
      clkIn   = 1'b0;
      dataIn  = 1'b0;
      dataAck = 1'b0;
      last_buf = '0;

      #2 rst = 1'b1;
      #1;
      check_all_zero("reset");
      tick(3);
      rst = 1'b0;
      tick(1);
      check_i("post-reset ready", int'(readyForReceive), 1);
      check_i("post-reset newData", int'(newData), 0);

      f1 = 256'h1 | (256'h1 << 255);
      f2 = {{15{16'h0303}}, 16'hAAAA};
      vt[0] = '{f1, 0, f1, 0};
      vt[1] = '{f2, 0, f2, 0};
      vt[2] = '{{FB{1'b1}}, 3, {FB{1'b1}}, 3};
      vt[3] = '{256'h0, 1, 256'h0, 1};
      vt[4] = '{{8{32'hDEADBEEF}}, 2, {8{32'hDEADBEEF}}, 2};

      for (int i = 0; i < 2; i++)
         run_vec($sformatf("vec%0d", i), vt[i].frame, vt[i].extra, vt[i].exp_buf, vt[i].exp_err, 1'b0);

      // Link stalls after 100 bits: exactly one timeout error, partial frame dropped.
      e0 = err_seen;
      for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom();
      send_bits(f, 100, 1'b0);
      tick(75);
      check_i("timeout pulses", err_seen - e0, 1);
      check_i("timeout newData", int'(newData), 0);
      check_i("timeout ready", int'(readyForReceive), 1);
      check_w("timeout buffer kept", receiveBuffer, last_buf);
      run_vec("after timeout", f, 0, f, 0, 1'b0);

      for (int i = 2; i < 5; i++)
         run_vec($sformatf("vec%0d", i), vt[i].frame, vt[i].extra, vt[i].exp_buf, vt[i].exp_err, 1'b0);

      // Reset in the middle of a frame.
      e0 = err_seen;
      send_bits(f2, 120, 1'b0);
      rst = 1'b1;
      #1;
      check_all_zero("mid-frame reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all_zero("reset held");
      rst = 1'b0;
      tick(1);
      check_i("after reset ready", int'(readyForReceive), 1);
      check_i("after reset newData", int'(newData), 0);
      check_i("after reset no error", err_seen - e0, 0);
      last_buf = '0;
      run_vec("frame after reset", f1, 0, f1, 0, 1'b0);

`ifdef SERIAL_RX_PARITY_EN
      // 256'h3 has even payload parity, so parity bit 1 is wrong and 0 is right.
      e0 = err_seen;
      send_bits(256'h3, FB, 1'b0);
      send_bit(1'b1, 4, 4);
      tick(6);
      check_i("parity fail pulse", err_seen - e0, 1);
      check_i("parity fail newData", int'(newData), 0);
      check_w("parity fail buffer kept", receiveBuffer, last_buf);
      run_vec("parity ok", 256'h3, 0, 256'h3, 0, 1'b0);
`endif

      // Random frames, random link timing, random overrun count and ack delay.
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom();
         extra = int'($urandom_range(0, 2));
         run_vec($sformatf("rand%0d", r), f, extra, f, extra, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
